// File: rtl/regfile_io_if.sv
// ----------------------------------------------------------------------------
// regfile_io_if
// Bundle of every non-clock, non-reset signal of the regfile_io block.
//
//   master : decode/ALU side. Drives read/write requests, the input stream and
//            the output-stream ready. Receives read data, stall and stream
//            status.
//   slave  : register file side (regfile_io itself).
//
// Signals
//   src_a, src_b   read port indices            rd_a_en, rd_b_en  operand used
//   dst, we, wdata write request
//   out_a, out_b   read data (combinational)    r0_out            stored r0
//   stall          current access cannot complete
//   io_in_*        input stream  (data, valid in; ready out of the slave)
//   io_out_*       output buffer (data, valid out of the slave; ready in)
// ----------------------------------------------------------------------------
interface regfile_io_if #(
  parameter int DATA_W = 32'd8,
  parameter int ADDR_W = 32'd3
);

  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              rd_a_en;
  logic              rd_b_en;
  logic [ADDR_W-1:0] dst;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] r0_out;
  logic              stall;
  logic [DATA_W-1:0] io_in_data;
  logic              io_in_valid;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_out_data;
  logic              io_out_valid;
  logic              io_out_ready;

  modport master (
    output src_a, src_b, rd_a_en, rd_b_en, dst, we, wdata,
    output io_in_data, io_in_valid, io_out_ready,
    input  out_a, out_b, r0_out, stall, io_in_ready, io_out_data, io_out_valid
  );

  modport slave (
    input  src_a, src_b, rd_a_en, rd_b_en, dst, we, wdata,
    input  io_in_data, io_in_valid, io_out_ready,
    output out_a, out_b, r0_out, stall, io_in_ready, io_out_data, io_out_valid
  );

endinterface

// File: rtl/regfile_io.sv
// ----------------------------------------------------------------------------
// regfile_io
// General-purpose register file with two combinational read ports, one write
// port, and one index (IO_REG) mapped onto a pair of valid/ready streams:
//   - reading IO_REG returns io_in_data and consumes one input word,
//   - writing IO_REG loads a single-entry output buffer.
// When an I/O access cannot complete, stall is raised and nothing commits
// (no register write, no input consumed, no output buffer load).
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears storage and the output buffer
//   bus    regfile_io_if.slave; see the interface for the signal list
//
// Parameters
//   DATA_W   data width                 NUM_REGS  number of indices (any value)
//   IO_REG   index mapped to streams    ZERO_R0   r0 hard-wired to zero
//   BYPASS   same-cycle write data forwarded to reads of the written index
// ----------------------------------------------------------------------------
module regfile_io #(
  parameter int DATA_W   = 32'd8,
  parameter int NUM_REGS = 32'd8,
  parameter int IO_REG   = 32'd7,
  parameter bit ZERO_R0  = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_io_if.slave  bus
);

  // A single-entry file still needs a one-bit index.
  localparam int ADDR_W = (NUM_REGS > 32'sd1) ? $clog2(NUM_REGS) : 32'sd1;
  localparam logic [ADDR_W-1:0] IO_IDX   = ADDR_W'(IO_REG);
  localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              io_out_valid_r;
  logic [DATA_W-1:0] io_out_data_r;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              need_in_s;
  logic              in_stall_s;
  logic              out_stall_s;
  logic              stall_s;
  logic              commit_s;
  logic              wr_io_s;
  logic              wr_reg_s;
  logic [DATA_W-1:0] stored_a_s;
  logic [DATA_W-1:0] stored_b_s;
  logic              byp_a_s;
  logic              byp_b_s;
  logic [DATA_W-1:0] rd_a_s;
  logic [DATA_W-1:0] rd_b_s;

  // True when an index has no backing storage (NUM_REGS need not be 2**ADDR_W).
  function automatic logic out_of_range(input logic [ADDR_W-1:0] idx);
    return (int'(idx) >= NUM_REGS);
  endfunction

  // Read mux for one port, in priority order: out of range, I/O stream,
  // hard-wired r0, write bypass, stored value.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored_val,
    input logic              byp_hit,
    input logic [DATA_W-1:0] wr_val,
    input logic [DATA_W-1:0] io_val
  );
    logic [DATA_W-1:0] v;
    if (out_of_range(idx)) begin
      v = ZERO_DAT;
    end else if (idx == IO_IDX) begin
      v = io_val;
    end else if (ZERO_R0 && (idx == ZERO_IDX)) begin
      v = ZERO_DAT;
    end else if (BYPASS && byp_hit) begin
      v = wr_val;
    end else begin
      v = stored_val;
    end
    return v;
  endfunction

  // Stall and commit decisions. Stall depends only on inputs and the
  // registered output-valid flag, so there is no combinational loop through
  // the read data or the handshakes.
  always_comb begin
    need_in_s   = (bus.rd_a_en && (bus.src_a == IO_IDX)) ||
                  (bus.rd_b_en && (bus.src_b == IO_IDX));
    in_stall_s  = need_in_s && !bus.io_in_valid;
    out_stall_s = bus.we && (bus.dst == IO_IDX) && io_out_valid_r && !bus.io_out_ready;
    stall_s     = in_stall_s || out_stall_s;
    commit_s    = bus.we && !stall_s;
    wr_io_s     = commit_s && (bus.dst == IO_IDX);
    wr_reg_s    = commit_s && (bus.dst != IO_IDX) && !out_of_range(bus.dst) &&
                  !(ZERO_R0 && (bus.dst == ZERO_IDX));
  end

  // Read ports: storage fetch guarded against missing indices, then the mux.
  always_comb begin
    if (out_of_range(bus.src_a)) begin
      stored_a_s = ZERO_DAT;
    end else begin
      stored_a_s = regs_r[bus.src_a];
    end
    if (out_of_range(bus.src_b)) begin
      stored_b_s = ZERO_DAT;
    end else begin
      stored_b_s = regs_r[bus.src_b];
    end
    byp_a_s = commit_s && (bus.dst == bus.src_a);
    byp_b_s = commit_s && (bus.dst == bus.src_b);
    rd_a_s  = read_sel(bus.src_a, stored_a_s, byp_a_s, bus.wdata, bus.io_in_data);
    rd_b_s  = read_sel(bus.src_b, stored_b_s, byp_b_s, bus.wdata, bus.io_in_data);
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------

  // Register storage: cleared on reset, written when a non-I/O write commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 32'sd0; i < NUM_REGS; i++) begin
        regs_r[i] <= ZERO_DAT;
      end
    end else if (wr_reg_s) begin
      regs_r[bus.dst] <= bus.wdata;
    end
  end

  // Output buffer: a committed I/O write loads it (a full buffer can drain
  // and refill on the same edge); otherwise an accepted word empties it and
  // the data register keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_out_valid_r <= 1'b0;
      io_out_data_r  <= ZERO_DAT;
    end else if (wr_io_s) begin
      io_out_valid_r <= 1'b1;
      io_out_data_r  <= bus.wdata;
    end else if (io_out_valid_r && bus.io_out_ready) begin
      io_out_valid_r <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.out_a        = rd_a_s;
  assign bus.out_b        = rd_b_s;
  assign bus.r0_out       = regs_r[0];
  assign bus.stall        = stall_s;
  // One word per cycle even when both ports read IO_REG.
  assign bus.io_in_ready  = need_in_s && !stall_s;
  assign bus.io_out_data  = io_out_data_r;
  assign bus.io_out_valid = io_out_valid_r;

endmodule

// File: tb/tb_regfile_io.sv
// Testbench for regfile_io. Two instances share one stimulus stream:
//   dut0: NUM_REGS=8, IO_REG=7, ZERO_R0=0, BYPASS=1
//   dut1: NUM_REGS=6, IO_REG=3, ZERO_R0=1, BYPASS=0
// A behavioural model (arrays plus the read/stall rules) predicts every output
// and is compared on each falling edge; directed steps add literal expectations.
module tb_regfile_io;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] src_a, src_b, dst;
  logic          rd_a_en, rd_b_en, we;
  logic [DW-1:0] wdata, io_in_data;
  logic          io_in_valid, io_out_ready;

  regfile_io_if #(.DATA_W(DW), .ADDR_W(AW)) bus [2] ();

  logic [DW-1:0] d_out_a [2];
  logic [DW-1:0] d_out_b [2];
  logic [DW-1:0] d_r0    [2];
  logic [DW-1:0] d_od    [2];
  logic          d_stall [2];
  logic          d_irdy  [2];
  logic          d_ov    [2];

  for (genvar g = 0; g < 2; g++) begin : g_bus
    assign bus[g].src_a        = src_a;
    assign bus[g].src_b        = src_b;
    assign bus[g].rd_a_en      = rd_a_en;
    assign bus[g].rd_b_en      = rd_b_en;
    assign bus[g].dst          = dst;
    assign bus[g].we           = we;
    assign bus[g].wdata        = wdata;
    assign bus[g].io_in_data   = io_in_data;
    assign bus[g].io_in_valid  = io_in_valid;
    assign bus[g].io_out_ready = io_out_ready;
    assign d_out_a[g] = bus[g].out_a;
    assign d_out_b[g] = bus[g].out_b;
    assign d_r0[g]    = bus[g].r0_out;
    assign d_od[g]    = bus[g].io_out_data;
    assign d_stall[g] = bus[g].stall;
    assign d_irdy[g]  = bus[g].io_in_ready;
    assign d_ov[g]    = bus[g].io_out_valid;
  end

  regfile_io #(.DATA_W(8), .NUM_REGS(8), .IO_REG(7), .ZERO_R0(1'b0), .BYPASS(1'b1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus[0]));
  regfile_io #(.DATA_W(8), .NUM_REGS(6), .IO_REG(3), .ZERO_R0(1'b1), .BYPASS(1'b0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus[1]));

  // ---------------- behavioural model ----------------
  int  P_NUM [2] = '{8, 6};
  int  P_IO  [2] = '{7, 3};
  bit  P_Z   [2] = '{1'b0, 1'b1};
  bit  P_BY  [2] = '{1'b1, 1'b0};

  logic [DW-1:0] m_regs [2][8];
  logic          m_ov   [2];
  logic [DW-1:0] m_od   [2];

  function automatic bit m_need(int k);
    return (rd_a_en && int'(src_a) == P_IO[k]) || (rd_b_en && int'(src_b) == P_IO[k]);
  endfunction

  function automatic bit m_stall(int k);
    bit blocked_out;
    blocked_out = we && int'(dst) == P_IO[k] && m_ov[k] && !io_out_ready;
    return (m_need(k) && !io_in_valid) || blocked_out;
  endfunction

  function automatic logic [DW-1:0] m_read(int k, logic [AW-1:0] idx);
    if (int'(idx) >= P_NUM[k]) return 8'h00;
    if (int'(idx) == P_IO[k]) return io_in_data;
    if (P_Z[k] && idx == 3'd0) return 8'h00;
    if (P_BY[k] && we && !m_stall(k) && dst == idx) return wdata;
    return m_regs[k][idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int r = 0; r < 8; r++) m_regs[k][r] <= 8'h00;
        m_ov[k] <= 1'b0;
        m_od[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we && !m_stall(k)) begin
          if (int'(dst) == P_IO[k]) begin
            m_od[k] <= wdata;
            m_ov[k] <= 1'b1;
          end else if (int'(dst) < P_NUM[k] && !(P_Z[k] && dst == 3'd0)) begin
            m_regs[k][dst] <= wdata;
          end
          if (int'(dst) != P_IO[k] && m_ov[k] && io_out_ready) m_ov[k] <= 1'b0;
        end else if (m_ov[k] && io_out_ready) begin
          m_ov[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk("model_out_a", k, 32'(d_out_a[k]), 32'(m_read(k, src_a)));
        chk("model_out_b", k, 32'(d_out_b[k]), 32'(m_read(k, src_b)));
        chk("model_r0", k, 32'(d_r0[k]), 32'(m_regs[k][0]));
        chk("model_stall", k, 32'(d_stall[k]), 32'(m_stall(k)));
        chk("model_in_ready", k, 32'(d_irdy[k]), 32'(m_need(k) && !m_stall(k)));
        chk("model_out_valid", k, 32'(d_ov[k]), 32'(m_ov[k]));
        chk("model_out_data", k, 32'(d_od[k]), 32'(m_od[k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    src_a = 3'd0; src_b = 3'd0; rd_a_en = 1'b0; rd_b_en = 1'b0;
    dst = 3'd0; we = 1'b0; wdata = 8'h00;
    io_in_data = 8'h00; io_in_valid = 1'b0; io_out_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #12;
    @(negedge clk);
    chk("reset_out_a", 0, 32'(d_out_a[0]), 32'h00);
    chk("reset_out_valid", 0, 32'(d_ov[0]), 32'h0);
    chk("reset_out_data", 1, 32'(d_od[1]), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1. write then read; same-cycle bypass
    we = 1'b1; dst = 3'd2; wdata = 8'h5A;
    tick();
    we = 1'b0; src_a = 3'd2;
    @(negedge clk);
    chk("t1_read", 0, 32'(d_out_a[0]), 32'h5A);
    chk("t1_read", 1, 32'(d_out_a[1]), 32'h5A);
    tick();
    we = 1'b1; dst = 3'd2; wdata = 8'hA5;
    @(negedge clk);
    chk("t1_bypass", 0, 32'(d_out_a[0]), 32'hA5);
    chk("t1_nobypass", 1, 32'(d_out_a[1]), 32'h5A);
    tick();

    // 2. input stall then completion
    rd_a_en = 1'b1; src_a = 3'd7; src_b = 3'd1; we = 1'b1; dst = 3'd1;
    wdata = 8'h33; io_in_data = 8'h33; io_in_valid = 1'b0;
    @(negedge clk);
    chk("t2_stall", 0, 32'(d_stall[0]), 32'h1);
    chk("t2_in_ready", 0, 32'(d_irdy[0]), 32'h0);
    chk("t2_r1_unchanged", 0, 32'(d_out_b[0]), 32'h00);
    tick();
    io_in_valid = 1'b1;
    @(negedge clk);
    chk("t2_in_ready_go", 0, 32'(d_irdy[0]), 32'h1);
    chk("t2_out_a", 0, 32'(d_out_a[0]), 32'h33);
    tick();
    idle(); src_b = 3'd1;
    @(negedge clk);
    chk("t2_r1", 0, 32'(d_out_b[0]), 32'h33);
    tick();

    // 3. output buffer full / refill
    we = 1'b1; dst = 3'd7; wdata = 8'h11;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("t3_valid", 0, 32'(d_ov[0]), 32'h1);
    chk("t3_data", 0, 32'(d_od[0]), 32'h11);
    tick();
    we = 1'b1; wdata = 8'h22;
    @(negedge clk);
    chk("t3_stall", 0, 32'(d_stall[0]), 32'h1);
    chk("t3_data_hold", 0, 32'(d_od[0]), 32'h11);
    tick();
    io_out_ready = 1'b1;
    @(negedge clk);
    chk("t3_unstall", 0, 32'(d_stall[0]), 32'h0);
    tick();
    we = 1'b0; io_out_ready = 1'b0;
    @(negedge clk);
    chk("t3_refill", 0, 32'(d_od[0]), 32'h22);
    chk("t3_refill_valid", 0, 32'(d_ov[0]), 32'h1);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained", 0, 32'(d_ov[0]), 32'h0);

    // 4. ZERO_R0 on dut1
    we = 1'b1; dst = 3'd0; wdata = 8'hFF;
    tick();
    we = 1'b0; src_a = 3'd0;
    @(negedge clk);
    chk("t4_zero_read", 1, 32'(d_out_a[1]), 32'h00);
    chk("t4_zero_r0", 1, 32'(d_r0[1]), 32'h00);
    chk("t4_r0_stored", 0, 32'(d_r0[0]), 32'hFF);
    tick();

    // 5. both ports read IO_REG
    rd_a_en = 1'b1; rd_b_en = 1'b1; src_a = 3'd7; src_b = 3'd7;
    io_in_valid = 1'b1; io_in_data = 8'h7C;
    @(negedge clk);
    chk("t5_out_a", 0, 32'(d_out_a[0]), 32'h7C);
    chk("t5_out_b", 0, 32'(d_out_b[0]), 32'h7C);
    chk("t5_in_ready", 0, 32'(d_irdy[0]), 32'h1);
    tick();
    idle();
    @(negedge clk);
    chk("t5_pulse_end", 0, 32'(d_irdy[0]), 32'h0);
    tick();

    // 6. asynchronous reset mid-cycle
    we = 1'b1; dst = 3'd7; wdata = 8'h99;
    tick();
    dst = 3'd5; wdata = 8'h44;
    tick();
    we = 1'b0; src_a = 3'd5;
    @(negedge clk);
    chk("t6_pre_r5", 0, 32'(d_out_a[0]), 32'h44);
    chk("t6_pre_valid", 0, 32'(d_ov[0]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 0, 32'(d_ov[0]), 32'h0);
    chk("t6_rst_r5", 0, 32'(d_out_a[0]), 32'h00);
    chk("t6_rst_data", 0, 32'(d_od[0]), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random phase, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      src_a = 3'($urandom_range(0, 7));
      src_b = 3'($urandom_range(0, 7));
      rd_a_en = 1'($urandom);
      rd_b_en = 1'($urandom);
      we = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: dst = 3'd7;
        1: dst = 3'd3;
        default: dst = 3'($urandom_range(0, 7));
      endcase
      wdata = 8'($urandom);
      io_in_data = 8'($urandom);
      io_in_valid = 1'($urandom);
      io_out_ready = ($urandom_range(0, 2) == 0);
      if (n == 1500) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
